uart_reg_bank: RTL and testbench

- 8-bit register file sitting between the UART byte link (rx/tx FIFO command decoder) and the ECG algorithm core.
- Exposes a control register, a read-only status register, an 11-bit ECG sample input split across two byte registers, and the 11-bit RR-period result split across two byte registers.
- Access is by single-cycle read/write request strobes with a 3-bit address.

---
 rtl/uart_reg_bank.sv | 141 ++++++++++++++
 tb/tb_uart_reg_bank.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/uart_reg_bank.sv
// Byte-wide register bank between the UART command decoder and the ECG algorithm core.
// Optional macro UART_REGS_RR_SNAPSHOT_EN: a DOUTL read freezes RR[10:8] for the following DOUTH read.
module uart_reg_bank (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [2:0]  i_rwaddr,
  input  logic [7:0]  i_write_data,
  input  logic        i_rd_req,
  input  logic        i_wr_req,
  input  logic [10:0] i_rr_period,
  input  logic        i_mas_valid,
  input  logic        i_mal_valid,
  input  logic        i_th_inited,
  input  logic        i_alg_active,
  input  logic        i_tx_fifo_e,
  input  logic        i_tx_fifo_f,
  input  logic        i_rx_fifo_e,
  input  logic        i_rx_fifo_f,
  output logic [7:0]  o_read_data,
  output logic [10:0] o_ecg_value,
  output logic        o_ecg_value_vld,
  output logic        o_alg_rst,
  output logic        o_alg_en,
  output logic        o_src_sel
);

  localparam logic [2:0] ADDR_CR    = 3'd0;
  localparam logic [2:0] ADDR_SR    = 3'd1;
  localparam logic [2:0] ADDR_DINL  = 3'd2;
  localparam logic [2:0] ADDR_DINH  = 3'd3;
  localparam logic [2:0] ADDR_DOUTL = 3'd4;
  localparam logic [2:0] ADDR_DOUTH = 3'd5;

  logic        w_wr_cr;
  logic        w_wr_dinl;
  logic        w_wr_dinh;
  logic [7:0]  w_status;
  logic [2:0]  w_rr_hi;
  logic [7:0]  w_rd_mux;

  logic        r_alg_en;
  logic        r_alg_rst;
  logic        r_src_sel;
  logic [7:0]  r_dinl;
  logic [2:0]  r_dinh;
  logic [10:0] r_ecg_value;
  logic        r_ecg_value_vld;
  logic [7:0]  r_read_data;

  assign w_wr_cr   = i_wr_req && (i_rwaddr == ADDR_CR);
  assign w_wr_dinl = i_wr_req && (i_rwaddr == ADDR_DINL);
  assign w_wr_dinh = i_wr_req && (i_rwaddr == ADDR_DINH);

  assign w_status = {i_rx_fifo_f, i_rx_fifo_e, i_tx_fifo_f, i_tx_fifo_e,
                     i_alg_active, i_th_inited, i_mal_valid, i_mas_valid};

  // alg_rst is never stored: it is a strobe derived straight from the write.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_alg_en  <= 1'b0;
      r_alg_rst <= 1'b0;
      r_src_sel <= 1'b0;
    end else begin
      r_alg_rst <= w_wr_cr && i_write_data[1];
      if (w_wr_cr) begin
        r_alg_en  <= i_write_data[0];
        r_src_sel <= i_write_data[2];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_dinl <= 8'h00;
      r_dinh <= 3'b000;
    end else begin
      if (w_wr_dinl) r_dinl <= i_write_data;
      if (w_wr_dinh) r_dinh <= i_write_data[2:0];
    end
  end

  // The DINH write is the commit point for a new sample.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ecg_value     <= 11'h000;
      r_ecg_value_vld <= 1'b0;
    end else begin
      r_ecg_value_vld <= w_wr_dinh;
      if (w_wr_dinh) r_ecg_value <= {i_write_data[2:0], r_dinl};
    end
  end

`ifdef UART_REGS_RR_SNAPSHOT_EN
  logic       w_rd_doutl;
  logic [2:0] r_rr_shadow;

  assign w_rd_doutl = i_rd_req && (i_rwaddr == ADDR_DOUTL);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rr_shadow <= 3'b000;
    end else if (w_rd_doutl) begin
      r_rr_shadow <= i_rr_period[10:8];
    end
  end

  assign w_rr_hi = r_rr_shadow;
`else
  assign w_rr_hi = i_rr_period[10:8];
`endif

  // Mux uses pre-edge register values, so a same-cycle write is not visible to the read.
  always_comb begin
    w_rd_mux = 8'h00;
    case (i_rwaddr)
      ADDR_CR:    w_rd_mux = {5'b00000, r_src_sel, 1'b0, r_alg_en};
      ADDR_SR:    w_rd_mux = w_status;
      ADDR_DINL:  w_rd_mux = r_dinl;
      ADDR_DINH:  w_rd_mux = {5'b00000, r_dinh};
      ADDR_DOUTL: w_rd_mux = i_rr_period[7:0];
      ADDR_DOUTH: w_rd_mux = {5'b00000, w_rr_hi};
      default:    w_rd_mux = 8'h00;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_read_data <= 8'h00;
    end else if (i_rd_req) begin
      r_read_data <= w_rd_mux;
    end
  end

  assign o_read_data     = r_read_data;
  assign o_ecg_value     = r_ecg_value;
  assign o_ecg_value_vld = r_ecg_value_vld;
  assign o_alg_rst       = r_alg_rst;
  assign o_alg_en        = r_alg_en;
  assign o_src_sel       = r_src_sel;

endmodule

// File: tb/tb_uart_reg_bank.sv
// Directed bench for uart_reg_bank; expected values are hand-computed constants.
module tb_uart_reg_bank;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic [2:0]  i_rwaddr = 3'd0;
  logic [7:0]  i_write_data = 8'h00;
  logic        i_rd_req = 1'b0;
  logic        i_wr_req = 1'b0;
  logic [10:0] i_rr_period = 11'h000;
  logic        i_mas_valid = 1'b0;
  logic        i_mal_valid = 1'b0;
  logic        i_th_inited = 1'b0;
  logic        i_alg_active = 1'b0;
  logic        i_tx_fifo_e = 1'b0;
  logic        i_tx_fifo_f = 1'b0;
  logic        i_rx_fifo_e = 1'b0;
  logic        i_rx_fifo_f = 1'b0;
  logic [7:0]  o_read_data;
  logic [10:0] o_ecg_value;
  logic        o_ecg_value_vld;
  logic        o_alg_rst;
  logic        o_alg_en;
  logic        o_src_sel;

  int n_checks = 0;
  int n_fail = 0;
  logic [7:0] rd;

  uart_reg_bank dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_rwaddr(i_rwaddr), .i_write_data(i_write_data),
    .i_rd_req(i_rd_req), .i_wr_req(i_wr_req), .i_rr_period(i_rr_period),
    .i_mas_valid(i_mas_valid), .i_mal_valid(i_mal_valid), .i_th_inited(i_th_inited),
    .i_alg_active(i_alg_active), .i_tx_fifo_e(i_tx_fifo_e), .i_tx_fifo_f(i_tx_fifo_f),
    .i_rx_fifo_e(i_rx_fifo_e), .i_rx_fifo_f(i_rx_fifo_f), .o_read_data(o_read_data),
    .o_ecg_value(o_ecg_value), .o_ecg_value_vld(o_ecg_value_vld), .o_alg_rst(o_alg_rst),
    .o_alg_en(o_alg_en), .o_src_sel(o_src_sel)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_write(input logic [2:0] addr, input logic [7:0] data);
    @(negedge i_clk);
    i_rwaddr = addr; i_write_data = data; i_wr_req = 1'b1;
    @(posedge i_clk); #1;
    i_wr_req = 1'b0;
  endtask

  task automatic do_read(input logic [2:0] addr, output logic [7:0] data);
    @(negedge i_clk);
    i_rwaddr = addr; i_rd_req = 1'b1;
    @(posedge i_clk); #1;
    i_rd_req = 1'b0;
    data = o_read_data;
  endtask

  task automatic idle_cycle();
    @(posedge i_clk); #1;
  endtask

  initial begin
    // reset state
    #12;
    check("rst_read_data", {8'h0, o_read_data}, 16'h0000);
    check("rst_ecg_value", {5'h0, o_ecg_value}, 16'h0000);
    check("rst_vld", {15'h0, o_ecg_value_vld}, 16'h0000);
    check("rst_alg_rst", {15'h0, o_alg_rst}, 16'h0000);
    check("rst_alg_en", {15'h0, o_alg_en}, 16'h0000);
    check("rst_src_sel", {15'h0, o_src_sel}, 16'h0000);
    @(negedge i_clk); i_rst_n = 1'b1;
    do_read(3'd0, rd);
    check("rst_cr_read", {8'h0, rd}, 16'h0000);
    do_read(3'd2, rd);
    check("rst_dinl_read", {8'h0, rd}, 16'h0000);

    // status register
    i_mas_valid = 0; i_mal_valid = 1; i_th_inited = 0; i_alg_active = 0;
    i_tx_fifo_e = 1; i_tx_fifo_f = 0; i_rx_fifo_e = 0; i_rx_fifo_f = 1;
    do_read(3'd1, rd);
    check("sr_read", {8'h0, rd}, 16'h0092);
    i_mas_valid = 1;
    idle_cycle();
    check("read_holds", {8'h0, o_read_data}, 16'h0092);
    do_write(3'd1, 8'h00);
    do_read(3'd1, rd);
    check("sr_write_ignored", {8'h0, rd}, 16'h0093);

    // RR period
    i_rr_period = 11'h7FF;
    do_read(3'd5, rd);
    check("douth_7ff", {8'h0, rd}, 16'h0007);
    do_read(3'd4, rd);
    check("doutl_7ff", {8'h0, rd}, 16'h00FF);
    i_rr_period = 11'h100;
    do_read(3'd5, rd);
`ifdef UART_REGS_RR_SNAPSHOT_EN
    check("douth_snapshot", {8'h0, rd}, 16'h0007);
`else
    check("douth_live", {8'h0, rd}, 16'h0001);
`endif

    // ECG sample input
    do_write(3'd2, 8'hFF);
    check("dinl_no_vld", {15'h0, o_ecg_value_vld}, 16'h0000);
    check("dinl_no_ecg", {5'h0, o_ecg_value}, 16'h0000);
    do_write(3'd3, 8'h07);
    check("dinh_vld", {15'h0, o_ecg_value_vld}, 16'h0001);
    check("dinh_ecg", {5'h0, o_ecg_value}, 16'h07FF);
    idle_cycle();
    check("vld_one_cycle", {15'h0, o_ecg_value_vld}, 16'h0000);
    check("ecg_holds", {5'h0, o_ecg_value}, 16'h07FF);
    do_write(3'd3, 8'hFA);
    check("dinh_mask_ecg", {5'h0, o_ecg_value}, 16'h02FF);
    do_read(3'd3, rd);
    check("dinh_readback", {8'h0, rd}, 16'h0002);
    do_read(3'd2, rd);
    check("dinl_readback", {8'h0, rd}, 16'h00FF);

    // control register
    do_write(3'd0, 8'hAA);
    check("cr_aa_rst", {15'h0, o_alg_rst}, 16'h0001);
    check("cr_aa_en", {15'h0, o_alg_en}, 16'h0000);
    check("cr_aa_src", {15'h0, o_src_sel}, 16'h0000);
    idle_cycle();
    check("alg_rst_one_cycle", {15'h0, o_alg_rst}, 16'h0000);
    do_read(3'd0, rd);
    check("cr_aa_read", {8'h0, rd}, 16'h0000);
    do_write(3'd0, 8'h05);
    check("cr_05_rst", {15'h0, o_alg_rst}, 16'h0000);
    check("cr_05_en", {15'h0, o_alg_en}, 16'h0001);
    check("cr_05_src", {15'h0, o_src_sel}, 16'h0001);
    do_read(3'd0, rd);
    check("cr_05_read", {8'h0, rd}, 16'h0005);

    // unused offsets and read-only DOUT
    do_write(3'd6, 8'h5A);
    do_write(3'd4, 8'h5A);
    do_read(3'd6, rd);
    check("addr6_read", {8'h0, rd}, 16'h0000);
    do_read(3'd7, rd);
    check("addr7_read", {8'h0, rd}, 16'h0000);
    do_read(3'd4, rd);
    check("doutl_write_ignored", {8'h0, rd}, 16'h0000);
    do_read(3'd0, rd);
    check("cr_untouched", {8'h0, rd}, 16'h0005);

    // simultaneous read and write to DINL
    @(negedge i_clk);
    i_rwaddr = 3'd2; i_write_data = 8'h3C; i_rd_req = 1'b1; i_wr_req = 1'b1;
    @(posedge i_clk); #1;
    i_rd_req = 1'b0; i_wr_req = 1'b0;
    check("rw_same_old", {8'h0, o_read_data}, 16'h00FF);
    do_read(3'd2, rd);
    check("rw_same_new", {8'h0, rd}, 16'h003C);

    // reset in the middle of a strobe
    i_rr_period = 11'h7FF;
    do_write(3'd3, 8'h01);
    check("pre_rst_vld", {15'h0, o_ecg_value_vld}, 16'h0001);
    i_rst_n = 1'b0;
    #1;
    check("mid_rst_vld", {15'h0, o_ecg_value_vld}, 16'h0000);
    check("mid_rst_ecg", {5'h0, o_ecg_value}, 16'h0000);
    check("mid_rst_en", {15'h0, o_alg_en}, 16'h0000);
    check("mid_rst_src", {15'h0, o_src_sel}, 16'h0000);
    check("mid_rst_rdata", {8'h0, o_read_data}, 16'h0000);
    @(negedge i_clk); i_rst_n = 1'b1;
    do_read(3'd2, rd);
    check("mid_rst_dinl", {8'h0, rd}, 16'h0000);
    do_read(3'd5, rd);
`ifdef UART_REGS_RR_SNAPSHOT_EN
    check("shadow_after_rst", {8'h0, rd}, 16'h0000);
`else
    check("douth_after_rst", {8'h0, rd}, 16'h0007);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
